// File: rtl/whirl_round_lut.sv
// Whirlpool round through an external registered C0 table: one table lookup per
// cycle over 64 cycles, accumulated as theta(pi(gamma(state))) XOR key.
module whirl_round_lut #(
  parameter int DLY = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [511:0] i_state,
  input  logic [511:0] i_key,
  output logic [7:0]   o_rom_addr,
  input  logic [63:0]  i_rom_data,
  output logic         o_busy,
  output logic         o_done,
  output logic [511:0] o_data
);

  // DLY carries no functional effect; register updates here are zero-delay.
  if (DLY < 0) begin : g_dly_invalid
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e       state_q, state_d;
  logic [5:0]   j_q, j_d;
  logic [511:0] st_q, st_d;
  logic [511:0] acc_q, acc_d;
  logic         tag_v_q, tag_v_d;
  logic [2:0]   tag_i_q, tag_i_d;
  logic [2:0]   tag_k_q, tag_k_d;
  logic         done_q, done_d;

  logic         start_acc;
  logic [2:0]   look_i, look_k, look_row;
  logic [5:0]   byte_n;
  logic [5:0]   rot_sh;
  logic [63:0]  rot_data;

  assign start_acc = (state_q == S_IDLE) && i_start;
  assign look_i    = j_q[5:3];
  assign look_k    = j_q[2:0];
  assign look_row  = look_i - look_k;
  assign byte_n    = {look_row, look_k};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          j_d     = '0;
        end
      end
      S_RUN: begin
        j_d = j_q + 6'd1;
        if (j_q == 6'd63) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_rom_addr = 8'h00;
    if (state_q == S_RUN) o_rom_addr = st_q[{~byte_n, 3'b111} -: 8];
  end

  assign o_done = done_q;
  assign o_data = acc_q;

  // The tag travels alongside the ROM's own register so the returning word
  // knows which row and rotation it belongs to.
  always_comb begin
    st_d     = start_acc ? i_state : st_q;
    tag_v_d  = (state_q == S_RUN);
    tag_i_d  = look_i;
    tag_k_d  = look_k;
    done_d   = (state_q == S_FLUSH);
    rot_sh   = {tag_k_q, 3'b000};
    rot_data = (i_rom_data >> rot_sh) | (i_rom_data << (7'd64 - {1'b0, rot_sh}));
    acc_d    = acc_q;
    if (start_acc) begin
      acc_d = i_key;
    end else if (tag_v_q) begin
      acc_d[{~tag_i_q, 6'h3f} -: 64] = acc_q[{~tag_i_q, 6'h3f} -: 64] ^ rot_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q    <= '0;
      acc_q   <= '0;
      tag_v_q <= 1'b0;
      tag_i_q <= '0;
      tag_k_q <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      acc_q   <= acc_d;
      tag_v_q <= tag_v_d;
      tag_i_q <= tag_i_d;
      tag_k_q <= tag_k_d;
      done_q  <= done_d;
    end
  end

endmodule
